// File: rtl/inst_encoder_writer.sv
// inst_encoder_writer: packs decomposed RV32I fields back into instruction
// words and streams them into instruction memory at consecutive addresses.
module inst_encoder_writer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_range,
  output logic              err_align,
  output logic              err_opcode,
  input  logic              clr_err,
  output logic              done
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] enc;
  logic        bad_range, bad_align, bad_op, bad;
  logic        accept;

  assign in_ready = (state == RUN) && (!mem_we || mem_ready);
  assign accept   = in_valid && in_ready;
  assign bad      = bad_range || bad_align || bad_op;

  // Format-specific immediate packing and legality checks
  always_comb begin
    enc       = '0;
    bad_range = 1'b0;
    bad_align = 1'b0;
    bad_op    = 1'b0;
    case (in_opcode)
      OP_R: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      OP_LOAD, OP_IMM, OP_JALR: begin
        enc       = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        bad_range = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      OP_STORE: begin
        enc       = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        bad_range = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      OP_BRANCH: begin
        enc       = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        bad_range = !((&in_imm[31:12]) || !(|in_imm[31:12]));
        bad_align = in_imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        enc       = {in_imm[31:12], in_rd, in_opcode};
        bad_range = |in_imm[11:0];
      end
      OP_JAL: begin
        enc       = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        bad_range = !((&in_imm[31:20]) || !(|in_imm[31:20]));
        bad_align = in_imm[0];
      end
      default: bad_op = 1'b1;
    endcase
  end

  // Session state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Session sequencing; done fires on the cycle DRAIN empties
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (accept && in_last) state_nxt = DRAIN;
      DRAIN: if (!mem_we) begin
        state_nxt = IDLE;
        done      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register and address counter; rejected bundles leave both untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      if (state == IDLE && start)  mem_addr <= BASE_ADDR;
      else if (mem_we && mem_ready) mem_addr <= mem_addr + ADDR_W'(4);
      if (accept && !bad) begin
        mem_we    <= 1'b1;
        mem_wdata <= enc;
      end else if (mem_ready) begin
        mem_we <= 1'b0;
      end
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_range  <= 1'b0;
      err_align  <= 1'b0;
      err_opcode <= 1'b0;
    end else begin
      err_range  <= (err_range  && !clr_err) || (accept && bad_range);
      err_align  <= (err_align  && !clr_err) || (accept && bad_align);
      err_opcode <= (err_opcode && !clr_err) || (accept && bad_op);
    end
  end

endmodule

// File: tb/tb_inst_encoder_writer.sv
// Directed bench for inst_encoder_writer; a second ADDR_W=4 instance shares
// all inputs to observe address wrap.
module tb_inst_encoder_writer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, mem_ready, clr_err;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;

  logic        in_ready, mem_we, err_range, err_align, err_opcode, done;
  logic [31:0] mem_addr, mem_wdata;
  logic        in_ready4, mem_we4, err_range4, err_align4, err_opcode4, done4;
  logic [3:0]  mem_addr4;
  logic [31:0] mem_wdata4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_encoder_writer #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .err_range(err_range), .err_align(err_align), .err_opcode(err_opcode),
    .clr_err(clr_err), .done(done)
  );

  inst_encoder_writer #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we4), .mem_ready(mem_ready), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .err_range(err_range4), .err_align(err_align4), .err_opcode(err_opcode4),
    .clr_err(clr_err), .done(done4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present a bundle, wait (bounded) for in_ready, complete the handshake
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic last);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid  = 1'b1;
    #1;
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) step();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL done_pulse: done never rose within 10 cycles, required 1");
    end
    step();
    vectors++;
    if (done !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL done_idle: done=%b in_ready=%b required 0 0", done, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_out: in_ready=%b mem_we=%b addr=%h wdata=%h required 0 0 0 0",
               in_ready, mem_we, mem_addr, mem_wdata);
    end
    vectors++;
    if ({err_range, err_align, err_opcode, done} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: rng/aln/op/done=%b required 0000",
               {err_range, err_align, err_opcode, done});
    end
    vectors++;
    if ({in_ready4, mem_we4, err_range4, err_align4, err_opcode4, done4} !== 6'b0 ||
        mem_addr4 !== 4'h0 || mem_wdata4 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_dut4: flags=%b addr=%h wdata=%h required 0 0 0",
               {in_ready4, mem_we4, err_range4, err_align4, err_opcode4, done4},
               mem_addr4, mem_wdata4);
    end
  endtask

  task automatic test_basic();
    do_start();
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hFFF0_0093) begin
      miscompares++;
      $display("FAIL addi: we=%b addr=%h wdata=%h required 1 00000000 fff00093",
               mem_we, mem_addr, mem_wdata);
    end
    wait_done();
    do_start();
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h0020_A423) begin
      miscompares++;
      $display("FAIL sw: we=%b addr=%h wdata=%h required 1 00000000 0020a423",
               mem_we, mem_addr, mem_wdata);
    end
    send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'hFE00_0EE3) begin
      miscompares++;
      $display("FAIL beq: we=%b addr=%h wdata=%h required 1 00000004 fe000ee3",
               mem_we, mem_addr, mem_wdata);
    end
    wait_done();
  endtask

  task automatic test_jal();
    do_start();
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1'b0);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h0010_00EF) begin
      miscompares++;
      $display("FAIL jal: we=%b addr=%h wdata=%h required 1 00000000 001000ef",
               mem_we, mem_addr, mem_wdata);
    end
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h3, 1'b0);
    vectors++;
    if (err_align !== 1'b1 || err_range !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL jal_odd: aln=%b rng=%b we=%b addr=%h required 1 0 0 00000004",
               err_align, err_range, mem_we, mem_addr);
    end
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1'b1);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h0010_00EF) begin
      miscompares++;
      $display("FAIL jal_reuse: we=%b addr=%h wdata=%h required 1 00000004 001000ef",
               mem_we, mem_addr, mem_wdata);
    end
    wait_done();
  endtask

  task automatic test_errors();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    vectors++;
    if ({err_range, err_align, err_opcode} !== 3'b000) begin
      miscompares++;
      $display("FAIL clr_err: rng/aln/op=%b required 000", {err_range, err_align, err_opcode});
    end
    do_start();
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 1'b0);
    vectors++;
    if (err_range !== 1'b1 || err_align !== 1'b0 || err_opcode !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL lui_range: rng=%b aln=%b op=%b we=%b required 1 0 0 0",
               err_range, err_align, err_opcode, mem_we);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
    vectors++;
    if (err_range !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL addi_range: rng=%b we=%b required 1 0", err_range, mem_we);
    end
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 1'b0);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h0020_81B3) begin
      miscompares++;
      $display("FAIL add_r: we=%b addr=%h wdata=%h required 1 00000000 002081b3",
               mem_we, mem_addr, mem_wdata);
    end
    clr_err = 1'b1;
    send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1);
    clr_err = 1'b0;
    vectors++;
    if (err_opcode !== 1'b1 || err_range !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_opcode: op=%b rng=%b we=%b required 1 0 0", err_opcode, err_range, mem_we);
    end
    wait_done();
  endtask

  task automatic test_backpressure();
    do_start();
    mem_ready = 1'b0;
    send(7'b0010011, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'h5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h0050_8113 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall[%0d]: we=%b addr=%h wdata=%h rdy=%b required 1 00000000 00508113 0",
                 i, mem_we, mem_addr, mem_wdata, in_ready);
      end
      step();
    end
    mem_ready = 1'b1;
    step();
    vectors++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h4 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release: we=%b addr=%h rdy=%b required 0 00000004 1", mem_we, mem_addr, in_ready);
    end
    send(7'b0010011, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'h5, 1'b1);
    wait_done();
  endtask

  task automatic test_reset_mid();
    do_start();
    mem_ready = 1'b0;
    send(7'b0010011, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'h5, 1'b0);
    start = 1'b1;
    mem_ready = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (mem_addr !== 32'h4 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_in_run: addr=%h rdy=%b required 00000004 1", mem_addr, in_ready);
    end
    mem_ready = 1'b0;
    send(7'b0010011, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'h5, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: we=%b addr=%h rdy=%b required 0 00000000 0", mem_we, mem_addr, in_ready);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_wrap();
    logic [3:0] ea;
    do_start();
    for (int k = 0; k < 5; k++) begin
      send(7'b0010011, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'h1, (k == 4));
      ea = 4'(k * 4);
      vectors++;
      if (mem_we4 !== 1'b1 || mem_addr4 !== ea) begin
        miscompares++;
        $display("FAIL wrap[%0d]: we=%b addr=%h required 1 %h", k, mem_we4, mem_addr4, ea);
      end
    end
    wait_done();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    mem_ready = 1'b1; clr_err = 1'b0;
    in_opcode = '0; in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_imm = '0;
    test_reset();
    test_basic();
    test_jal();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
